// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA core datapath.
// Holds the Montgomery multiplier FSM encoding and latency figures.
package rsa_pkg;

    typedef enum logic [1:0] {
        MMM_IDLE = 2'd0,
        MMM_RUN  = 2'd1,
        MMM_SUB  = 2'd2,
        MMM_DONE = 2'd3
    } mmm_state_t;

    // R guard bits: R < 2M and t + M < 4M
    localparam int MMM_EXTRA_BITS = 2;

    localparam int MMM_LAT_OFS_SUB   = 1;
    localparam int MMM_LAT_OFS_NOSUB = 0;

    function automatic int mmm_latency(input int width, input bit final_sub);
        return width + (final_sub ? MMM_LAT_OFS_SUB : MMM_LAT_OFS_NOSUB);
    endfunction

endpackage

// File: rtl/mmm_step.sv
// One radix-2 Montgomery iteration: R' = (R + a*B + q*M) / 2.
// Purely combinational; one instance per iteration lane.
module mmm_step
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+MMM_EXTRA_BITS-1:0] r_i,
    input  logic                            a_bit,
    input  logic [WIDTH-1:0]                b_i,
    input  logic [WIDTH-1:0]                m_i,
    output logic [WIDTH+MMM_EXTRA_BITS-1:0] r_o
);

    localparam int RW = WIDTH + MMM_EXTRA_BITS;

    logic [RW-1:0] b_ext;
    logic [RW-1:0] m_ext;
    logic [RW-1:0] t;
    logic [RW-1:0] u;

    always_comb begin
        b_ext = {{MMM_EXTRA_BITS{1'b0}}, b_i};
        m_ext = {{MMM_EXTRA_BITS{1'b0}}, m_i};
        t     = r_i + (a_bit ? b_ext : '0);
        u     = t + (t[0] ? m_ext : '0);
        r_o   = u >> 1;
    end

endmodule

// File: rtl/mmm_serial.sv
// Bit-serial radix-2 Montgomery multiplier, P = A*B*2^-WIDTH mod M.
// Define MMM_FINAL_SUB_EN to add the final conditional-subtract state.
module mmm_serial
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             rst_mmm,
    input  logic             ld_a,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   p,
    output logic             done,
    output logic             busy
);

    localparam int RW = WIDTH + MMM_EXTRA_BITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mmm_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [RW-1:0]    r_q, r_d;
    logic [WIDTH:0]   p_q, p_d;
    logic             done_q, done_d;
    logic [RW-1:0]    r_step;

    mmm_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i  (r_q),
        .a_bit(a_q[0]),
        .b_i  (b_q),
        .m_i  (m_q),
        .r_o  (r_step)
    );

`ifdef MMM_FINAL_SUB_EN
    logic [RW-1:0] m_ext;
    logic [RW-1:0] r_red;

    always_comb begin
        m_ext = {{MMM_EXTRA_BITS{1'b0}}, m_q};
        r_red = (r_q >= m_ext) ? (r_q - m_ext) : r_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        r_d     = r_q;
        p_d     = p_q;
        done_d  = done_q;
        if (ena) begin
            if (!rst_mmm) begin
                state_d = MMM_IDLE;
                cnt_d   = '0;
                r_d     = '0;
                p_d     = '0;
                done_d  = 1'b0;
            end else if (ld_a) begin
                state_d = MMM_RUN;
                cnt_d   = '0;
                a_d     = a;
                b_d     = b;
                m_d     = m;
                r_d     = '0;
                done_d  = 1'b0;
            end else begin
                unique case (state_q)
                    MMM_RUN: begin
                        r_d = r_step;
                        a_d = a_q >> 1;
                        if (cnt_q == CNT_LAST) begin
`ifdef MMM_FINAL_SUB_EN
                            state_d = MMM_SUB;
`else
                            state_d = MMM_DONE;
                            p_d     = r_step[WIDTH:0];
                            done_d  = 1'b1;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
`ifdef MMM_FINAL_SUB_EN
                    MMM_SUB: begin
                        p_d     = r_red[WIDTH:0];
                        done_d  = 1'b1;
                        state_d = MMM_DONE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= MMM_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            r_q     <= r_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign p    = p_q;
    assign done = done_q;
    assign busy = (state_q == MMM_RUN) || (state_q == MMM_SUB);

endmodule
